// File: rtl/imem_bus_arbiter.sv
// imem_bus_arbiter: shares the instruction-side memory bus between the icache
// refill engine (BURST_LEN-beat bursts) and the MMU page-table walker (single
// beats). PTW has fixed priority; a saturating starvation counter hands the bus
// to a waiting icache after STARVE_MAX consecutive PTW grants. A fetch kill
// during a refill drains the outstanding beats silently so the bus is never
// left half-owned.
module imem_bus_arbiter #(
    parameter int XLEN       = 32,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_i,
    input  logic [XLEN-1:0]   ic_addr_i,
    input  logic              ic_kill_i,
    output logic              ic_ack_o,
    output logic              ic_last_o,
    output logic [DATA_W-1:0] ic_rdata_o,
    input  logic              ptw_req_i,
    input  logic [XLEN-1:0]   ptw_addr_i,
    output logic              ptw_ack_o,
    output logic [DATA_W-1:0] ptw_rdata_o,
    output logic              bus_req_o,
    output logic [XLEN-1:0]   bus_addr_o,
    output logic              bus_burst_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [BW-1:0] C_LAST_BEAT  = BW'(BURST_LEN - 1);
    localparam logic [SW-1:0] C_STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IC  = 2'd1,
        GNT_PTW = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_bus_req;
    logic [XLEN-1:0]   r_bus_addr;
    logic              r_bus_burst;
    logic              r_owner;
    logic              r_busy;
    logic [BW-1:0]     r_beat_cnt;
    logic [SW-1:0]     r_starve_cnt;

    logic              w_ic_ok;
    logic              w_favour_ic;
    logic              w_grant_ic;
    logic              w_grant_ptw;
    logic              w_last_beat;
    logic              w_counting;

    // An icache request killed in the same cycle is never eligible.
    assign w_ic_ok     = ic_req_i & ~ic_kill_i;
    assign w_favour_ic = (r_starve_cnt == C_STARVE_LIM) & ic_req_i;
    assign w_grant_ic  = (r_state == IDLE) & w_ic_ok & (w_favour_ic | ~ptw_req_i);
    assign w_grant_ptw = (r_state == IDLE) & ptw_req_i & ~w_grant_ic;
    assign w_last_beat = (r_beat_cnt == C_LAST_BEAT);
    assign w_counting  = (r_state == GNT_IC) | (r_state == DRAIN);

    // Read data is steered straight through; the ack strobes qualify it.
    assign ic_rdata_o  = bus_rdata_i;
    assign ptw_rdata_o = bus_rdata_i;

    assign bus_req_o   = r_bus_req;
    assign bus_addr_o  = r_bus_addr;
    assign bus_burst_o = r_bus_burst;
    assign owner_o     = r_owner;
    assign busy_o      = r_busy;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: arbitrate in IDLE, leave a grant on its final ack.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_ic) begin
                    w_next_state = GNT_IC;
                end else if (w_grant_ptw) begin
                    w_next_state = GNT_PTW;
                end else begin
                    w_next_state = IDLE;
                end
            end
            GNT_PTW: begin
                if (bus_ack_i) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GNT_PTW;
                end
            end
            GNT_IC: begin
                // A kill landing on the final beat has nothing left to drain.
                if (bus_ack_i && w_last_beat) begin
                    w_next_state = IDLE;
                end else if (ic_kill_i) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = GNT_IC;
                end
            end
            DRAIN: begin
                if (bus_ack_i && w_last_beat) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output logic: acks follow the bus combinationally for the current owner;
    // a killed or draining refill sees no beats.
    always_comb begin
        ic_ack_o  = 1'b0;
        ic_last_o = 1'b0;
        ptw_ack_o = 1'b0;
        case (r_state)
            GNT_IC: begin
                ic_ack_o  = bus_ack_i & ~ic_kill_i;
                ic_last_o = bus_ack_i & ~ic_kill_i & w_last_beat;
            end
            GNT_PTW: begin
                ptw_ack_o = bus_ack_i;
            end
            default: begin
                ic_ack_o  = 1'b0;
                ic_last_o = 1'b0;
                ptw_ack_o = 1'b0;
            end
        endcase
    end

    // Bus-side registers: request held for the whole ownership, address,
    // burst flag and owner captured only at the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_busy      <= 1'b0;
            r_bus_addr  <= {XLEN{1'b0}};
            r_bus_burst <= 1'b0;
            r_owner     <= 1'b0;
        end else begin
            r_bus_req <= (w_next_state != IDLE);
            r_busy    <= (w_next_state != IDLE);
            if (w_grant_ic) begin
                r_bus_addr  <= ic_addr_i;
                r_bus_burst <= 1'b1;
                r_owner     <= 1'b0;
            end else if (w_grant_ptw) begin
                r_bus_addr  <= ptw_addr_i;
                r_bus_burst <= 1'b0;
                r_owner     <= 1'b1;
            end else begin
                r_bus_addr  <= r_bus_addr;
                r_bus_burst <= r_bus_burst;
                r_owner     <= r_owner;
            end
        end
    end

    // Beat counter: counts every burst ack, delivered or drained, and wraps
    // back to zero on the final beat so each refill starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= {BW{1'b0}};
        end else if (w_counting && bus_ack_i) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end

    // Starvation counter: PTW grants taken over a live icache request,
    // saturating; forgotten once the icache is served or stops asking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {SW{1'b0}};
        end else if (r_state == IDLE) begin
            if (w_grant_ic || !ic_req_i) begin
                r_starve_cnt <= {SW{1'b0}};
            end else if (w_grant_ptw && w_ic_ok && (r_starve_cnt != C_STARVE_LIM)) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end

endmodule

// File: tb/tb_imem_bus_arbiter.sv
// Directed bench for imem_bus_arbiter. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge. The status vector packs
// {bus_req, busy, ic_ack, ic_last, ptw_ack} for compact expected values.
module tb_imem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ic_req_i;
    logic [31:0] ic_addr_i;
    logic        ic_kill_i;
    logic        ic_ack_o;
    logic        ic_last_o;
    logic [31:0] ic_rdata_o;
    logic        ptw_req_i;
    logic [31:0] ptw_addr_i;
    logic        ptw_ack_o;
    logic [31:0] ptw_rdata_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_burst_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        busy_o;
    logic        owner_o;

    logic [4:0]  st;
    logic [4:0]  exp_st;
    int          total;
    int          bad;

    assign st = {bus_req_o, busy_o, ic_ack_o, ic_last_o, ptw_ack_o};

    imem_bus_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ic_req_i    (ic_req_i),
        .ic_addr_i   (ic_addr_i),
        .ic_kill_i   (ic_kill_i),
        .ic_ack_o    (ic_ack_o),
        .ic_last_o   (ic_last_o),
        .ic_rdata_o  (ic_rdata_o),
        .ptw_req_i   (ptw_req_i),
        .ptw_addr_i  (ptw_addr_i),
        .ptw_ack_o   (ptw_ack_o),
        .ptw_rdata_o (ptw_rdata_o),
        .bus_req_o   (bus_req_o),
        .bus_addr_o  (bus_addr_o),
        .bus_burst_o (bus_burst_o),
        .bus_ack_i   (bus_ack_i),
        .bus_rdata_i (bus_rdata_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
    );

    // 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_ack_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (st !== 5'b00000) begin
            $display("FAIL reset_status: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        if ({bus_addr_o, bus_burst_o, owner_o} !== 34'h0) begin
            $display("FAIL reset_regs: got addr=%h burst=%b owner=%b want 0", bus_addr_o, bus_burst_o, owner_o); bad++;
        end
        total++;
        bus_ack_i = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lone_ic();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_1000;
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL lone_req_latency: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        step();
        @(negedge clk);
        if (st !== 5'b11000 || bus_addr_o !== 32'h0000_1000 || bus_burst_o !== 1'b1 || owner_o !== 1'b0) begin
            $display("FAIL lone_grant: got st=%b addr=%h burst=%b owner=%b want 11000 00001000 1 0",
                     st, bus_addr_o, bus_burst_o, owner_o); bad++;
        end
        total++;
        step();
        for (int b = 0; b < 4; b++) begin
            bus_ack_i = 1'b1; bus_rdata_i = 32'hC0DE_0000 + 32'(b);
            exp_st = {2'b11, 1'b1, (b == 3), 1'b0};
            @(negedge clk);
            if (st !== exp_st || ic_rdata_o !== 32'hC0DE_0000 + 32'(b)) begin
                $display("FAIL lone_beat%0d: got st=%b data=%h want %b %h", b, st, ic_rdata_o,
                         exp_st, 32'hC0DE_0000 + 32'(b)); bad++;
            end
            total++;
            step();
        end
        // Bus ack arriving while IDLE must not reach either requester.
        ic_req_i = 1'b0; bus_ack_i = 1'b1;
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL lone_release_idle_ack: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        step();
        bus_ack_i = 1'b0;
    endtask

    task automatic test_collision();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_1000;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h0000_2000;
        step();
        bus_ack_i = 1'b1; bus_rdata_i = 32'hAAAA_5555;
        @(negedge clk);
        if (st !== 5'b11001 || owner_o !== 1'b1 || bus_addr_o !== 32'h0000_2000 ||
            bus_burst_o !== 1'b0 || ptw_rdata_o !== 32'hAAAA_5555) begin
            $display("FAIL coll_ptw_first: got st=%b owner=%b addr=%h burst=%b data=%h want 11001 1 00002000 0 aaaa5555",
                     st, owner_o, bus_addr_o, bus_burst_o, ptw_rdata_o); bad++;
        end
        total++;
        step();
        ptw_req_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL coll_gap: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        step();
        @(negedge clk);
        if (st !== 5'b11000 || owner_o !== 1'b0 || bus_addr_o !== 32'h0000_1000) begin
            $display("FAIL coll_ic_second: got st=%b owner=%b addr=%h want 11000 0 00001000",
                     st, owner_o, bus_addr_o); bad++;
        end
        total++;
        bus_ack_i = 1'b1;
        repeat (4) step();
        ic_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
    endtask

    task automatic test_starvation();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_5000;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h0000_2000;
        for (int g = 0; g < 3; g++) begin
            step();
            bus_ack_i = 1'b1;
            @(negedge clk);
            if (st !== 5'b11001 || owner_o !== 1'b1) begin
                $display("FAIL starve_ptw%0d: got st=%b owner=%b want 11001 1", g, st, owner_o); bad++;
            end
            total++;
            step();
            bus_ack_i = 1'b0;
        end
        step();
        @(negedge clk);
        if (st !== 5'b11000 || owner_o !== 1'b0 || bus_addr_o !== 32'h0000_5000) begin
            $display("FAIL starve_ic_win: got st=%b owner=%b addr=%h want 11000 0 00005000",
                     st, owner_o, bus_addr_o); bad++;
        end
        total++;
        bus_ack_i = 1'b1;
        repeat (4) step();
        ic_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
        @(negedge clk);
        if (st !== 5'b11000 || owner_o !== 1'b1) begin
            $display("FAIL starve_ptw_after: got st=%b owner=%b want 11000 1", st, owner_o); bad++;
        end
        total++;
        bus_ack_i = 1'b1;
        step();
        ptw_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
    endtask

    task automatic test_kill_mid();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_3000;
        step();
        bus_ack_i = 1'b1;
        repeat (2) step();
        ic_kill_i = 1'b1; bus_ack_i = 1'b0;
        ptw_req_i = 1'b1; ptw_addr_i = 32'h0000_6000;
        @(negedge clk);
        if (st !== 5'b11000) begin
            $display("FAIL kill_cycle: got %b want %b", st, 5'b11000); bad++;
        end
        total++;
        step();
        ic_req_i = 1'b0; ic_kill_i = 1'b0; bus_ack_i = 1'b1;
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            if (st !== 5'b11000) begin
                $display("FAIL drain_beat%0d: got %b want %b", d, st, 5'b11000); bad++;
            end
            total++;
            step();
        end
        bus_ack_i = 1'b0;
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL drain_exit: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        step();
        @(negedge clk);
        if (st !== 5'b11000 || owner_o !== 1'b1 || bus_addr_o !== 32'h0000_6000) begin
            $display("FAIL kill_ptw_grant: got st=%b owner=%b addr=%h want 11000 1 00006000",
                     st, owner_o, bus_addr_o); bad++;
        end
        total++;
        bus_ack_i = 1'b1;
        step();
        ptw_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
    endtask

    task automatic test_kill_last();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_4000;
        step();
        bus_ack_i = 1'b1;
        repeat (3) step();
        ic_kill_i = 1'b1;
        @(negedge clk);
        if (st !== 5'b11000) begin
            $display("FAIL kill_last_beat: got %b want %b", st, 5'b11000); bad++;
        end
        total++;
        step();
        ic_req_i = 1'b0; ic_kill_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL kill_last_no_drain: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        step();
    endtask

    task automatic test_reset_mid();
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_7000;
        step();
        bus_ack_i = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        if (st !== 5'b00000 || bus_addr_o !== 32'h0 || bus_burst_o !== 1'b0 || owner_o !== 1'b0) begin
            $display("FAIL rst_mid: got st=%b addr=%h burst=%b owner=%b want all 0",
                     st, bus_addr_o, bus_burst_o, owner_o); bad++;
        end
        total++;
        ic_req_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        @(negedge clk);
        if (st !== 5'b00000) begin
            $display("FAIL rst_release_idle: got %b want %b", st, 5'b00000); bad++;
        end
        total++;
        // Fresh refill after reset: last beat must fall on the fourth ack.
        ic_req_i = 1'b1; ic_addr_i = 32'h0000_8000;
        step();
        bus_ack_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            exp_st = {2'b11, 1'b1, (b == 3), 1'b0};
            @(negedge clk);
            if (st !== exp_st) begin
                $display("FAIL rst_refill_beat%0d: got %b want %b", b, st, exp_st); bad++;
            end
            total++;
            step();
        end
        ic_req_i = 1'b0; bus_ack_i = 1'b0;
        step();
    endtask

    initial begin
        total = 0; bad = 0;
        ic_req_i = 1'b0; ic_addr_i = 32'h0; ic_kill_i = 1'b0;
        ptw_req_i = 1'b0; ptw_addr_i = 32'h0;
        bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
        rst_n = 1'b0;
        test_reset();
        test_lone_ic();
        test_collision();
        test_starvation();
        test_kill_mid();
        test_kill_last();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
